// File: rtl/rv2t_csr_access_ctl_pkg.sv
// Shared constants and FSM encoding for the Zicsr access sequencer.
package rv2t_csr_access_ctl_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned CSR_ADDR_BITS = 12;
    localparam int unsigned REG_ADDR_BITS = 5;

    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;
    localparam logic [2:0] F3_CSRRC = 3'b011;
    localparam logic [2:0] F3_IMM   = 3'b100;

    // csr_addr[11:10] == 2'b11 marks the read-only CSR space
    localparam logic [CSR_ADDR_BITS-1:0] CSR_RO_MASK = 12'hC00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_FIN     = 3'd5
    } state_e;

endpackage

// File: rtl/rv2t_csr_access_ctl.sv
// Sequences one Zicsr instruction (read, read-modify-write compute, write) against the CSR block,
// returning the old CSR value for rd writeback and flagging illegal accesses.
module rv2t_csr_access_ctl #(
    parameter int unsigned XLEN          = rv2t_csr_access_ctl_pkg::XLEN,
    parameter int unsigned CSR_ADDR_BITS = rv2t_csr_access_ctl_pkg::CSR_ADDR_BITS,
    parameter int unsigned REG_ADDR_BITS = rv2t_csr_access_ctl_pkg::REG_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sync_reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [2:0]               funct3,
    input  logic [CSR_ADDR_BITS-1:0] csr_addr,
    input  logic [XLEN-1:0]          rs1_data,
    input  logic [REG_ADDR_BITS-1:0] rs1_uimm,
    input  logic [REG_ADDR_BITS-1:0] rd_addr,
    output logic                     csr_read_enable,
    output logic [CSR_ADDR_BITS-1:0] csr_read_addr,
    input  logic                     csr_read_en_in,
    input  logic [XLEN-1:0]          csr_read_data_in,
    output logic                     csr_write_enable,
    output logic [CSR_ADDR_BITS-1:0] csr_write_addr,
    output logic [XLEN-1:0]          csr_write_data,
    input  logic                     csr_fault_in,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_write_enable,
    output logic [REG_ADDR_BITS-1:0] rd_write_addr,
    output logic [XLEN-1:0]          rd_write_data,
    output logic                     illegal_csr
);
    import rv2t_csr_access_ctl_pkg::*;

    localparam logic [CSR_ADDR_BITS-1:0] RO_MASK = CSR_ADDR_BITS'(CSR_RO_MASK);

    // Bitwise read-modify-write of the CSR value
    function automatic logic [XLEN-1:0] f_rmw(input logic [1:0]      op,
                                              input logic [XLEN-1:0] old_val,
                                              input logic [XLEN-1:0] opnd);
        logic [XLEN-1:0] res;
        res = opnd;
        if (op == F3_CSRRS[1:0]) res = old_val | opnd;
        if (op == F3_CSRRC[1:0]) res = old_val & ~opnd;
        return res;
    endfunction

    state_e                   r_state, w_state_nxt;
    logic [1:0]               r_op, w_op_nxt;
    logic [CSR_ADDR_BITS-1:0] r_addr, w_addr_nxt;
    logic [XLEN-1:0]          r_operand, w_operand_nxt;
    logic [XLEN-1:0]          r_old, w_old_nxt;
    logic [XLEN-1:0]          r_new, w_new_nxt;
    logic [REG_ADDR_BITS-1:0] r_rd, w_rd_nxt;
    logic                     r_do_write, w_do_write_nxt;
    logic                     r_illegal, w_illegal_nxt;

    logic            w_is_rw;
    logic            w_do_read;
    logic            w_do_write;
    logic            w_illegal_acc;
    logic [XLEN-1:0] w_operand;
    logic            w_rd_req;
    logic            w_wr_req;
    logic            w_fin;

    // Accept-time decode straight from the execute-stage inputs
    always_comb begin
        w_is_rw       = (funct3[1:0] == F3_CSRRW[1:0]);
        w_operand     = ((funct3 & F3_IMM) != 3'b000) ? XLEN'(rs1_uimm) : rs1_data;
        w_do_read     = !(w_is_rw && (rd_addr == '0));
        w_do_write    = w_is_rw || (rs1_uimm != '0);
        w_illegal_acc = (funct3[1:0] == 2'b00) ||
                        (w_do_write && ((csr_addr & RO_MASK) == RO_MASK));
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_op_nxt       = r_op;
        w_addr_nxt     = r_addr;
        w_operand_nxt  = r_operand;
        w_old_nxt      = r_old;
        w_new_nxt      = r_new;
        w_rd_nxt       = r_rd;
        w_do_write_nxt = r_do_write;
        w_illegal_nxt  = r_illegal;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_op_nxt       = funct3[1:0];
                    w_addr_nxt     = csr_addr;
                    w_operand_nxt  = w_operand;
                    w_rd_nxt       = rd_addr;
                    w_do_write_nxt = w_do_write;
                    w_illegal_nxt  = w_illegal_acc;
                    w_old_nxt      = '0;
                    w_new_nxt      = w_operand;
                    if (w_illegal_acc)  w_state_nxt = ST_FIN;
                    else if (w_do_read) w_state_nxt = ST_RD_REQ;
                    else                w_state_nxt = ST_WR_REQ;
                end
            end
            ST_RD_REQ: w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (csr_fault_in) begin
                    w_illegal_nxt = 1'b1;
                    w_state_nxt   = ST_FIN;
                end else if (csr_read_en_in) begin
                    w_old_nxt   = csr_read_data_in;
                    w_new_nxt   = f_rmw(r_op, csr_read_data_in, r_operand);
                    w_state_nxt = r_do_write ? ST_WR_REQ : ST_FIN;
                end
            end
            ST_WR_REQ: w_state_nxt = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (csr_fault_in) w_illegal_nxt = 1'b1;
                w_state_nxt = ST_FIN;
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase

        if (abort) w_state_nxt = ST_IDLE;

        // Synchronous reset folds into the next-state values
        if (sync_reset) begin
            w_state_nxt    = ST_IDLE;
            w_op_nxt       = '0;
            w_addr_nxt     = '0;
            w_operand_nxt  = '0;
            w_old_nxt      = '0;
            w_new_nxt      = '0;
            w_rd_nxt       = '0;
            w_do_write_nxt = 1'b0;
            w_illegal_nxt  = 1'b0;
        end

        w_rd_req = (w_state_nxt == ST_RD_REQ);
        w_wr_req = (w_state_nxt == ST_WR_REQ);
        w_fin    = (w_state_nxt == ST_FIN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_op             <= '0;
            r_addr           <= '0;
            r_operand        <= '0;
            r_old            <= '0;
            r_new            <= '0;
            r_rd             <= '0;
            r_do_write       <= 1'b0;
            r_illegal        <= 1'b0;
            busy             <= 1'b0;
            csr_read_enable  <= 1'b0;
            csr_read_addr    <= '0;
            csr_write_enable <= 1'b0;
            csr_write_addr   <= '0;
            csr_write_data   <= '0;
            done             <= 1'b0;
            illegal_csr      <= 1'b0;
            rd_write_enable  <= 1'b0;
            rd_write_addr    <= '0;
            rd_write_data    <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_op             <= w_op_nxt;
            r_addr           <= w_addr_nxt;
            r_operand        <= w_operand_nxt;
            r_old            <= w_old_nxt;
            r_new            <= w_new_nxt;
            r_rd             <= w_rd_nxt;
            r_do_write       <= w_do_write_nxt;
            r_illegal        <= w_illegal_nxt;
            busy             <= (w_state_nxt != ST_IDLE);
            csr_read_enable  <= w_rd_req;
            csr_read_addr    <= w_rd_req ? w_addr_nxt : '0;
            csr_write_enable <= w_wr_req;
            csr_write_addr   <= w_wr_req ? w_addr_nxt : '0;
            csr_write_data   <= w_wr_req ? w_new_nxt : '0;
            done             <= w_fin;
            illegal_csr      <= w_fin && w_illegal_nxt;
            rd_write_enable  <= w_fin && !w_illegal_nxt && (w_rd_nxt != '0);
            rd_write_addr    <= w_fin ? w_rd_nxt : '0;
            rd_write_data    <= w_fin ? w_old_nxt : '0;
        end
    end

endmodule

// File: tb/tb_rv2t_csr_access_ctl.sv
// Directed self-checking bench for rv2t_csr_access_ctl.
module tb_rv2t_csr_access_ctl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sync_reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [11:0] csr_addr = '0;
    logic [31:0] rs1_data = '0;
    logic [4:0]  rs1_uimm = '0;
    logic [4:0]  rd_addr = '0;
    logic        csr_read_enable;
    logic [11:0] csr_read_addr;
    logic        csr_read_en_in = 1'b0;
    logic [31:0] csr_read_data_in = '0;
    logic        csr_write_enable;
    logic [11:0] csr_write_addr;
    logic [31:0] csr_write_data;
    logic        csr_fault_in = 1'b0;
    logic        busy;
    logic        done;
    logic        rd_write_enable;
    logic [4:0]  rd_write_addr;
    logic [31:0] rd_write_data;
    logic        illegal_csr;

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int both_cnt = 0;

    rv2t_csr_access_ctl dut (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
        .start(start), .abort(abort), .funct3(funct3), .csr_addr(csr_addr),
        .rs1_data(rs1_data), .rs1_uimm(rs1_uimm), .rd_addr(rd_addr),
        .csr_read_enable(csr_read_enable), .csr_read_addr(csr_read_addr),
        .csr_read_en_in(csr_read_en_in), .csr_read_data_in(csr_read_data_in),
        .csr_write_enable(csr_write_enable), .csr_write_addr(csr_write_addr),
        .csr_write_data(csr_write_data), .csr_fault_in(csr_fault_in),
        .busy(busy), .done(done), .rd_write_enable(rd_write_enable),
        .rd_write_addr(rd_write_addr), .rd_write_data(rd_write_data),
        .illegal_csr(illegal_csr)
    );

    always #5 clk = ~clk;

    // Bus activity monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (csr_read_enable) rd_cnt++;
        if (csr_write_enable) wr_cnt++;
        if (done) done_cnt++;
        if (csr_read_enable && csr_write_enable) both_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                         input logic [4:0] u, input logic [4:0] rd);
        funct3 = f3; csr_addr = a; rs1_data = d; rs1_uimm = u; rd_addr = rd;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, csr_read_enable, csr_write_enable, rd_write_enable, illegal_csr} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b exp 000000",
                {busy, done, csr_read_enable, csr_write_enable, rd_write_enable, illegal_csr});
        end
        checks++;
        if ({csr_read_addr, csr_write_addr, csr_write_data, rd_write_addr, rd_write_data} !== 93'b0) begin
            errors++; $display("FAIL reset_data: got %h exp 0",
                {csr_read_addr, csr_write_addr, csr_write_data, rd_write_addr, rd_write_data});
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_csrrw();
        issue(3'b001, 12'h340, 32'h1234_5678, 5'd7, 5'd5);
        checks++;
        if ({csr_read_enable, csr_write_enable, busy, csr_read_addr} !== {3'b101, 12'h340}) begin
            errors++; $display("FAIL rw_read_req: got %b/%b/%b/%h exp 1/0/1/340",
                csr_read_enable, csr_write_enable, busy, csr_read_addr);
        end
        step();
        csr_read_en_in = 1'b1; csr_read_data_in = 32'hAAAA_0000;
        step();
        csr_read_en_in = 1'b0; csr_read_data_in = '0;
        checks++;
        if ({csr_write_enable, csr_read_enable, csr_write_addr, csr_write_data} !== {2'b10, 12'h340, 32'h1234_5678}) begin
            errors++; $display("FAIL rw_write_req: got %b/%b/%h/%h exp 1/0/340/12345678",
                csr_write_enable, csr_read_enable, csr_write_addr, csr_write_data);
        end
        step();
        checks++;
        if ({csr_write_enable, done} !== 2'b00) begin
            errors++; $display("FAIL rw_wr_wait: got we=%b done=%b exp 0/0", csr_write_enable, done);
        end
        step();
        checks++;
        if ({done, rd_write_enable, illegal_csr, rd_write_addr, rd_write_data} !== {3'b110, 5'd5, 32'hAAAA_0000}) begin
            errors++; $display("FAIL rw_done: got %b%b%b rd=%0d data=%h exp 110 rd=5 data=aaaa0000",
                done, rd_write_enable, illegal_csr, rd_write_addr, rd_write_data);
        end
        step();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++; $display("FAIL rw_idle: got done=%b busy=%b exp 0/0", done, busy);
        end
    endtask

    task automatic test_read_only();
        int w0;
        w0 = wr_cnt;
        issue(3'b010, 12'hB00, 32'hFFFF_FFFF, 5'd0, 5'd3);
        checks++;
        if (csr_read_enable !== 1'b1) begin
            errors++; $display("FAIL ro_read_req: got %b exp 1", csr_read_enable);
        end
        step();
        csr_read_en_in = 1'b1; csr_read_data_in = 32'h0000_00C8;
        step();
        csr_read_en_in = 1'b0; csr_read_data_in = '0;
        checks++;
        if ({done, rd_write_enable, illegal_csr, rd_write_addr, rd_write_data} !== {3'b110, 5'd3, 32'h0000_00C8}) begin
            errors++; $display("FAIL ro_done: got %b%b%b rd=%0d data=%h exp 110 rd=3 data=000000c8",
                done, rd_write_enable, illegal_csr, rd_write_addr, rd_write_data);
        end
        step();
        checks++;
        if (wr_cnt - w0 !== 0) begin
            errors++; $display("FAIL ro_no_write: got %0d writes exp 0", wr_cnt - w0);
        end
    endtask

    task automatic test_csrrci_rd0();
        issue(3'b111, 12'h300, 32'hFFFF_FFFF, 5'h08, 5'd0);
        step();
        csr_read_en_in = 1'b1; csr_read_data_in = 32'h0000_1888;
        step();
        csr_read_en_in = 1'b0; csr_read_data_in = '0;
        checks++;
        if ({csr_write_enable, csr_write_addr, csr_write_data} !== {1'b1, 12'h300, 32'h0000_1880}) begin
            errors++; $display("FAIL rci_write: got %b/%h/%h exp 1/300/00001880",
                csr_write_enable, csr_write_addr, csr_write_data);
        end
        step();
        step();
        checks++;
        if ({done, rd_write_enable, illegal_csr} !== 3'b100) begin
            errors++; $display("FAIL rci_done: got %b%b%b exp 100", done, rd_write_enable, illegal_csr);
        end
        step();
    endtask

    task automatic test_write_only();
        int r0;
        r0 = rd_cnt;
        issue(3'b101, 12'h340, 32'h0, 5'h1F, 5'd0);
        checks++;
        if ({csr_write_enable, csr_read_enable, csr_write_data} !== {2'b10, 32'h0000_001F}) begin
            errors++; $display("FAIL wo_write: got %b/%b/%h exp 1/0/0000001f",
                csr_write_enable, csr_read_enable, csr_write_data);
        end
        step();
        step();
        checks++;
        if ({done, rd_write_enable, illegal_csr, rd_write_data} !== {3'b100, 32'h0}) begin
            errors++; $display("FAIL wo_done: got %b%b%b data=%h exp 100 data=0",
                done, rd_write_enable, illegal_csr, rd_write_data);
        end
        step();
        checks++;
        if (rd_cnt - r0 !== 0) begin
            errors++; $display("FAIL wo_no_read: got %0d reads exp 0", rd_cnt - r0);
        end
    endtask

    task automatic test_illegal_accept();
        int r0;
        int w0;
        r0 = rd_cnt; w0 = wr_cnt;
        issue(3'b001, 12'hF11, 32'h1, 5'd1, 5'd2);
        checks++;
        if ({done, illegal_csr, rd_write_enable} !== 3'b110) begin
            errors++; $display("FAIL ro_csr_done: got %b%b%b exp 110", done, illegal_csr, rd_write_enable);
        end
        step();
        checks++;
        if ({rd_cnt - r0, wr_cnt - w0, 1'b0, done, busy} !== {64'd0, 3'b000}) begin
            errors++; $display("FAIL ro_csr_bus: got rd=%0d wr=%0d done=%b busy=%b exp 0/0/0/0",
                rd_cnt - r0, wr_cnt - w0, done, busy);
        end
        issue(3'b000, 12'h340, 32'h1, 5'd1, 5'd2);
        checks++;
        if ({done, illegal_csr, rd_write_enable} !== 3'b110) begin
            errors++; $display("FAIL f3_zero: got %b%b%b exp 110", done, illegal_csr, rd_write_enable);
        end
        step();
        // Reading a read-only CSR without writing it is legal
        issue(3'b110, 12'hF11, 32'h0, 5'd0, 5'd4);
        checks++;
        if (csr_read_enable !== 1'b1) begin
            errors++; $display("FAIL ro_csr_read: got %b exp 1", csr_read_enable);
        end
        step();
        csr_read_en_in = 1'b1; csr_read_data_in = 32'h0000_0489;
        step();
        csr_read_en_in = 1'b0; csr_read_data_in = '0;
        checks++;
        if ({done, illegal_csr, rd_write_enable, rd_write_data} !== {3'b101, 32'h0000_0489}) begin
            errors++; $display("FAIL ro_csr_read_done: got %b%b%b data=%h exp 101 data=00000489",
                done, illegal_csr, rd_write_enable, rd_write_data);
        end
        step();
    endtask

    task automatic test_fault();
        int w0;
        w0 = wr_cnt;
        issue(3'b010, 12'h7C0, 32'h1, 5'd4, 5'd6);
        step();
        csr_fault_in = 1'b1;
        step();
        csr_fault_in = 1'b0;
        checks++;
        if ({done, illegal_csr, rd_write_enable} !== 3'b110) begin
            errors++; $display("FAIL rd_fault_done: got %b%b%b exp 110", done, illegal_csr, rd_write_enable);
        end
        step();
        checks++;
        if (wr_cnt - w0 !== 0) begin
            errors++; $display("FAIL rd_fault_no_write: got %0d writes exp 0", wr_cnt - w0);
        end
        // Fault reported on the write response
        issue(3'b001, 12'h7C1, 32'h5, 5'd1, 5'd0);
        step();
        csr_fault_in = 1'b1;
        step();
        csr_fault_in = 1'b0;
        checks++;
        if ({done, illegal_csr, rd_write_enable} !== 3'b110) begin
            errors++; $display("FAIL wr_fault_done: got %b%b%b exp 110", done, illegal_csr, rd_write_enable);
        end
        step();
    endtask

    task automatic test_abort_back_to_back();
        int d0;
        d0 = done_cnt;
        issue(3'b001, 12'h340, 32'h1111_1111, 5'd1, 5'd5);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({busy, done, illegal_csr, rd_write_enable} !== 4'b0000) begin
            errors++; $display("FAIL abort_idle: got %b%b%b%b exp 0000", busy, done, illegal_csr, rd_write_enable);
        end
        // Late fault for the aborted read lands in the same cycle as the next start
        csr_fault_in = 1'b1;
        issue(3'b010, 12'h341, 32'h0000_0F0F, 5'd3, 5'd9);
        csr_fault_in = 1'b0;
        checks++;
        if ({csr_read_enable, csr_read_addr, done} !== {1'b1, 12'h341, 1'b0}) begin
            errors++; $display("FAIL b2b_read_req: got %b/%h done=%b exp 1/341 done=0",
                csr_read_enable, csr_read_addr, done);
        end
        issue(3'b000, 12'hF11, 32'h0, 5'd0, 5'd1);
        csr_read_en_in = 1'b1; csr_read_data_in = 32'h0000_F000;
        step();
        csr_read_en_in = 1'b0; csr_read_data_in = '0;
        checks++;
        if ({csr_write_enable, csr_write_addr, csr_write_data} !== {1'b1, 12'h341, 32'h0000_FF0F}) begin
            errors++; $display("FAIL b2b_write: got %b/%h/%h exp 1/341/0000ff0f",
                csr_write_enable, csr_write_addr, csr_write_data);
        end
        step();
        step();
        checks++;
        if ({done, illegal_csr, rd_write_enable, rd_write_addr, rd_write_data} !== {3'b101, 5'd9, 32'h0000_F000}) begin
            errors++; $display("FAIL b2b_done: got %b%b%b rd=%0d data=%h exp 101 rd=9 data=0000f000",
                done, illegal_csr, rd_write_enable, rd_write_addr, rd_write_data);
        end
        step();
        step();
        checks++;
        if ({done_cnt - d0, busy} !== {32'd1, 1'b0}) begin
            errors++; $display("FAIL abort_done_count: got %0d busy=%b exp 1 busy=0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_sync_reset();
        int d0;
        d0 = done_cnt;
        issue(3'b001, 12'h340, 32'h2222_2222, 5'd1, 5'd5);
        sync_reset = 1'b1;
        step();
        sync_reset = 1'b0;
        checks++;
        if ({busy, csr_read_enable, csr_write_enable, csr_read_addr} !== 15'b0) begin
            errors++; $display("FAIL sync_reset: got busy=%b re=%b we=%b addr=%h exp 0/0/0/000",
                busy, csr_read_enable, csr_write_enable, csr_read_addr);
        end
        repeat (4) step();
        checks++;
        if ({done_cnt - d0, busy} !== {32'd0, 1'b0}) begin
            errors++; $display("FAIL sync_reset_quiet: got done=%0d busy=%b exp 0/0", done_cnt - d0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_csrrw();
        test_read_only();
        test_csrrci_rd0();
        test_write_only();
        test_illegal_accept();
        test_fault();
        test_abort_back_to_back();
        test_sync_reset();
        checks++;
        if (both_cnt !== 0) begin
            errors++; $display("FAIL req_exclusive: got %0d overlapping cycles exp 0", both_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
